// File: rtl/psg_master_dac.sv
`default_nettype none
// ============================================================================
// Module   : psg_master_dac
// Purpose  : PSG output stage. Scales the summed audio by a master volume,
//            saturates it to OWID bits and drives a 1st-order sigma-delta pin.
// Revision : 1.0 - initial release
// ============================================================================
module psg_master_dac #(
  parameter int WID   = 22,
  parameter int OWID  = 16,
  parameter int SHIFT = 9
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [7:0]      cnt,
  input  logic [3:0]      vol,
  input  logic [WID-1:0]  i,
  output logic [OWID-1:0] o,
  output logic            o_v,
  output logic            sd_o
);

  localparam int c_pw = WID + 4;
  localparam logic [c_pw-1:0] c_sat_max = {{(c_pw-OWID){1'b0}}, {OWID{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_SAT  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [WID-1:0]  r_a;
  logic [WID-1:0]  w_a_next;
  logic [3:0]      r_v;
  logic [3:0]      w_v_next;
  logic [c_pw-1:0] r_p;
  logic [c_pw-1:0] w_p_next;
  logic [1:0]      r_k;
  logic [1:0]      w_k_next;
  logic [OWID-1:0] r_o;
  logic [OWID-1:0] w_o_next;
  logic            r_ov;
  logic            w_ov_next;
  logic [OWID:0]   r_acc;
  logic [OWID:0]   w_acc_next;
  logic [c_pw-1:0] w_addend;
  logic [c_pw-1:0] w_s;

  // One partial product per MUL cycle: the latched sample shifted by the bit index.
  assign w_addend = {4'b0000, r_a} << r_k;
  assign w_s      = r_p >> SHIFT;

  always_comb begin
    w_state_next = r_state;
    w_a_next     = r_a;
    w_v_next     = r_v;
    w_p_next     = r_p;
    w_k_next     = r_k;
    w_o_next     = r_o;
    w_ov_next    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cnt == 8'd1) begin
          w_a_next     = i;
          w_v_next     = vol;
          w_p_next     = '0;
          w_k_next     = 2'd0;
          w_state_next = S_MUL;
        end
      end
      S_MUL: begin
        if (r_v[r_k]) begin
          w_p_next = r_p + w_addend;
        end
        w_k_next = r_k + 2'd1;
        if (r_k == 2'd3) begin
          w_state_next = S_SAT;
        end
      end
      S_SAT: begin
        w_o_next     = (w_s > c_sat_max) ? c_sat_max[OWID-1:0] : w_s[OWID-1:0];
        w_ov_next    = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_v     <= '0;
      r_p     <= '0;
      r_k     <= '0;
      r_o     <= '0;
      r_ov    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_a     <= w_a_next;
      r_v     <= w_v_next;
      r_p     <= w_p_next;
      r_k     <= w_k_next;
      r_o     <= w_o_next;
      r_ov    <= w_ov_next;
    end
  end

  // The carry out of the residue accumulator is the bitstream; its density is o / 2^OWID.
  assign w_acc_next = {1'b0, r_acc[OWID-1:0]} + {1'b0, r_o};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_acc_next;
    end
  end

  assign o    = r_o;
  assign o_v  = r_ov;
  assign sd_o = r_acc[OWID];

endmodule
`default_nettype wire
